ex_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipeline's execute stage. It drives the execute-stage operand-forwarding selects (ForwardAE/ForwardBE) and raises the fetch/decode/execute stall and flush strobes. It also sequences multicycle execute operations by holding them in EX for a fixed number of cycles while bubbles drain into MEM. It sits beside the execute cycle and consumes register addresses and control bits from the D, E, M and W pipeline registers.

---
 rtl/ex_hazard_if.sv | 42 ++++
 rtl/ex_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ex_hazard_if.sv
// Execute-stage hazard bundle: pipeline register fields into the hazard
// controller, forwarding selects and stall/flush strobes back out.
interface ex_hazard_if;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic [4:0]  Rs1E;
   logic [4:0]  Rs2E;
   logic [4:0]  RdE;
   logic [4:0]  RdM;
   logic [4:0]  RdW;
   logic        RegWriteM;
   logic        RegWriteW;
   logic        ResultSrcE;
   logic        PCSrcE;
   logic        McStartE;

   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic        StallF;
   logic        StallD;
   logic        StallE;
   logic        FlushD;
   logic        FlushE;
   logic        BubbleM;
   logic        BusyE;
   logic [15:0] StallCnt;

   // The pipeline side drives register fields and consumes the strobes.
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartE,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, BubbleM, BusyE, StallCnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartE,
      output ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, BubbleM, BusyE, StallCnt
   );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall,
// branch flush and a fixed-latency multicycle sequencer with stall counter.
module ex_hazard_ctrl #(
   parameter int MC_LATENCY = 4
) (
   input  logic   clk,
   input  logic   rst,
   ex_hazard_if.slave hz
);

   typedef enum logic {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   localparam bit         MC_EN    = (MC_LATENCY > 1);
   localparam logic [3:0] CNT_LOAD = MC_EN ? 4'(MC_LATENCY - 2) : 4'd0;

   state_t      state;
   state_t      state_next;
   logic [3:0]  cnt;
   logic [3:0]  cnt_next;
   logic [15:0] stall_cnt;
   logic        mc_active;
   logic        load_use;

   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic        stall_f;
   logic        stall_d;
   logic        stall_e;
   logic        flush_d;
   logic        flush_e;
   logic        bubble_m;

   // M-stage producer is younger than W, so it takes precedence.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       reg_write_m,
      input logic [4:0] rd_m,
      input logic       reg_write_w,
      input logic [4:0] rd_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
         sel = 2'b10;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
   end

   assign load_use = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         stall_cnt <= 16'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (stall_f && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // The cycle where cnt reaches zero in MC_BUSY is the release cycle: the op
   // advances to M, and McStartE still seen there must not retrigger.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mc_active  = 1'b0;
      case (state)
         IDLE: begin
            if (MC_EN && hz.McStartE) begin
               mc_active  = 1'b1;
               state_next = MC_BUSY;
               cnt_next   = CNT_LOAD;
            end
         end
         MC_BUSY: begin
            if (cnt != 4'd0) begin
               mc_active = 1'b1;
               cnt_next  = cnt - 4'd1;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      bubble_m = 1'b0;
      if (mc_active) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         bubble_m = 1'b1;
      end else if (hz.PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (load_use) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   // Reset masks every output, forwarding included.
   assign hz.ForwardAE = rst ? 2'b00  : fwd_a;
   assign hz.ForwardBE = rst ? 2'b00  : fwd_b;
   assign hz.StallF    = rst ? 1'b0   : stall_f;
   assign hz.StallD    = rst ? 1'b0   : stall_d;
   assign hz.StallE    = rst ? 1'b0   : stall_e;
   assign hz.FlushD    = rst ? 1'b0   : flush_d;
   assign hz.FlushE    = rst ? 1'b0   : flush_e;
   assign hz.BubbleM   = rst ? 1'b0   : bubble_m;
   assign hz.BusyE     = rst ? 1'b0   : stall_e;
   assign hz.StallCnt  = rst ? 16'd0  : stall_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: expected outputs are queued per cycle
// and compared against the DUT at the falling edge.
module tb_ex_hazard_ctrl;

   logic clk;
   logic rst;

   ex_hazard_if hz ();

   ex_hazard_ctrl #(.MC_LATENCY(4)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   typedef struct {
      string       tag;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [5:0]  strb;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sbq[$];
   int          checks;
   int          failures;
   logic [15:0] expCnt;

   localparam logic [5:0] S_NONE  = 6'b000000;
   localparam logic [5:0] S_MC    = 6'b111001;
   localparam logic [5:0] S_FLUSH = 6'b000110;
   localparam logic [5:0] S_LU    = 6'b110010;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearInputs();
      hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
      hz.RdE = 5'd0;  hz.RdM = 5'd0;  hz.RdW = 5'd0;
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 1'b0;
      hz.PCSrcE = 1'b0; hz.McStartE = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkField(input string tag, input string field,
                             input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $error("[TB] FAIL scoreboard observed=empty expected=entry");
         return;
      end
      e = sbq.pop_front();
      checkField(e.tag, "ForwardAE", 16'(hz.ForwardAE), 16'(e.fa));
      checkField(e.tag, "ForwardBE", 16'(hz.ForwardBE), 16'(e.fb));
      checkField(e.tag, "strobes",
                 16'({hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.BubbleM}),
                 16'(e.strb));
      checkField(e.tag, "BusyE", 16'(hz.BusyE), 16'(e.strb[3]));
      checkField(e.tag, "StallCnt", hz.StallCnt, e.cnt);
   endtask

   // Queue this cycle's expectation, then compare on the falling edge.
   task automatic applyStimulus(input string tag, input logic [1:0] fa,
                                input logic [1:0] fb, input logic [5:0] strb);
      exp_t e;
      e.tag = tag;
      if (rst) begin
         e.fa = 2'b00; e.fb = 2'b00; e.strb = S_NONE; e.cnt = 16'd0;
         sbq.push_back(e);
         expCnt = 16'd0;
      end else begin
         e.fa = fa; e.fb = fb; e.strb = strb; e.cnt = expCnt;
         sbq.push_back(e);
         if (strb[5] && (expCnt != 16'hFFFF))
            expCnt = expCnt + 16'd1;
      end
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      expCnt   = 16'd0;
      rst      = 1'b1;
      clearInputs();
      hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5;
      hz.McStartE = 1'b1; hz.PCSrcE = 1'b1;
      applyStimulus("reset", 2'b00, 2'b00, S_NONE);

      // Forwarding selects.
      nextCycle(); rst = 1'b0; clearInputs();
      hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
      hz.Rs1E = 5'd5; hz.Rs2E = 5'd0;
      applyStimulus("fwd_m_wins", 2'b10, 2'b00, S_NONE);
      nextCycle(); hz.RdM = 5'd0;
      applyStimulus("fwd_rdm0", 2'b01, 2'b00, S_NONE);
      nextCycle(); hz.RdM = 5'd5; hz.RegWriteM = 1'b0; hz.Rs2E = 5'd5;
      applyStimulus("fwd_w_both", 2'b01, 2'b01, S_NONE);
      nextCycle(); hz.RegWriteM = 1'b1; hz.RdW = 5'd9; hz.Rs2E = 5'd9;
      applyStimulus("fwd_split", 2'b10, 2'b01, S_NONE);

      // Load-use: one stall, then the dependent instruction forwards from M.
      nextCycle(); clearInputs();
      hz.ResultSrcE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      applyStimulus("lu_stall", 2'b00, 2'b00, S_LU);
      nextCycle(); clearInputs();
      hz.RdM = 5'd7; hz.RegWriteM = 1'b1; hz.Rs2E = 5'd7;
      applyStimulus("lu_fwd", 2'b00, 2'b10, S_NONE);
      nextCycle(); clearInputs();
      hz.ResultSrcE = 1'b1; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
      applyStimulus("lu_rd0", 2'b00, 2'b00, S_NONE);

      // Two back-to-back multicycle ops; branch and load-use ignored while busy.
      nextCycle(); clearInputs(); hz.McStartE = 1'b1;
      applyStimulus("mc0", 2'b00, 2'b00, S_MC);
      nextCycle(); hz.PCSrcE = 1'b1; hz.ResultSrcE = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
      applyStimulus("mc1_prio", 2'b00, 2'b00, S_MC);
      nextCycle(); clearInputs(); hz.McStartE = 1'b1;
      applyStimulus("mc2", 2'b00, 2'b00, S_MC);
      nextCycle();
      applyStimulus("mc3_release", 2'b00, 2'b00, S_NONE);
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         applyStimulus("mc_again", 2'b00, 2'b00, S_MC);
      end
      nextCycle();
      applyStimulus("mc_again_release", 2'b00, 2'b00, S_NONE);
      nextCycle(); hz.McStartE = 1'b0;
      applyStimulus("mc_idle", 2'b00, 2'b00, S_NONE);

      // Branch priority over load-use.
      nextCycle(); hz.PCSrcE = 1'b1; hz.ResultSrcE = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd7;
      applyStimulus("br_over_lu", 2'b00, 2'b00, S_FLUSH);
      nextCycle(); clearInputs(); hz.PCSrcE = 1'b1;
      applyStimulus("br_only", 2'b00, 2'b00, S_FLUSH);

      // Reset in the middle of a multicycle op.
      nextCycle(); clearInputs(); hz.McStartE = 1'b1;
      applyStimulus("rmid0", 2'b00, 2'b00, S_MC);
      nextCycle(); rst = 1'b1;
      applyStimulus("rmid_rst", 2'b00, 2'b00, S_NONE);
      nextCycle(); rst = 1'b0; hz.McStartE = 1'b0;
      applyStimulus("rmid_idle", 2'b00, 2'b00, S_NONE);
      nextCycle(); hz.McStartE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus("rmid_restart", 2'b00, 2'b00, S_MC);
         nextCycle();
      end
      applyStimulus("rmid_release", 2'b00, 2'b00, S_NONE);

      // Saturation of the stall counter under a held load-use hazard.
      nextCycle(); clearInputs();
      hz.ResultSrcE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
         if (expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
      end
      #1;
      applyStimulus("sat", 2'b00, 2'b00, S_LU);
      nextCycle(); clearInputs();
      applyStimulus("sat_hold", 2'b00, 2'b00, S_NONE);

      nextCycle(); rst = 1'b1;
      applyStimulus("final_rst", 2'b00, 2'b00, S_NONE);
      nextCycle(); rst = 1'b0;
      applyStimulus("final_clear", 2'b00, 2'b00, S_NONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
